// File: rtl/reg_read_sequencer_if.sv
// Bus between the register read sequencer, the instruction source, the
// register block and the SPI byte buffer. The sequencer sits on the
// slave side; the master modport is for whoever drives instructions
// and read data and consumes bytes.
interface reg_read_sequencer_if;
    logic [7:0]  reg_addr;
    logic        instr_valid_reg_stuff;
    logic        status_reg_read;
    logic        error_reg_read;
    logic [31:0] read_vals;
    logic        reg_valid_read;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        bad_addr;
    logic        timeout_err;

    modport slave (
        input  reg_addr,
        input  instr_valid_reg_stuff,
        input  read_vals,
        input  reg_valid_read,
        input  byte_ready,
        output status_reg_read,
        output error_reg_read,
        output byte_out,
        output byte_valid,
        output busy,
        output bad_addr,
        output timeout_err
    );

    modport master (
        output reg_addr,
        output instr_valid_reg_stuff,
        output read_vals,
        output reg_valid_read,
        output byte_ready,
        input  status_reg_read,
        input  error_reg_read,
        input  byte_out,
        input  byte_valid,
        input  busy,
        input  bad_addr,
        input  timeout_err
    );
endinterface

// File: rtl/reg_read_sequencer.sv
// Register read sequencer: accepts a read instruction for the status
// (8'h00) or error (8'h04) register, strobes the register block, waits
// for the read data (bounded by a timeout that substitutes FILL_WORD),
// then streams the 32-bit word MSB byte first into the SPI byte buffer.
// Every output comes straight from a flop whose next value is derived
// from the next state, so nothing combinational reaches the pins.
module reg_read_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] FILL_WORD      = 32'hDEAD_BEEF
) (
    input logic                  sysClk,
    input logic                  rst_n,
    reg_read_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        SEND   = 2'd3
    } state_t;

    // Last legal WAIT count; the counter starts at 0 so this gives
    // exactly TIMEOUT_CYCLES WAIT cycles before the fill word is used.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    // Only two addresses are legal, so one bit fully identifies the
    // latched address: 1 selects the error register.
    logic        sel_err_q, sel_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;

    logic        status_rd_q, status_rd_d;
    logic        error_rd_q, error_rd_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        busy_q, busy_d;
    logic        bad_addr_q, bad_addr_d;
    logic        timeout_err_q, timeout_err_d;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        sel_err_d     = sel_err_q;
        wait_cnt_d    = wait_cnt_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        bad_addr_d    = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid_reg_stuff) begin
                    if (bus.reg_addr == 8'h00 || bus.reg_addr == 8'h04) begin
                        sel_err_d = (bus.reg_addr == 8'h04);
                        state_d   = STROBE;
                    end else begin
                        bad_addr_d = 1'b1;
                    end
                end
            end
            STROBE: begin
                wait_cnt_d = 8'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.reg_valid_read) begin
                    shift_d    = bus.read_vals;
                    byte_cnt_d = 2'd0;
                    state_d    = SEND;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    shift_d       = FILL_WORD;
                    byte_cnt_d    = 2'd0;
                    timeout_err_d = 1'b1;
                    state_d       = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            SEND: begin
                if (bus.byte_ready) begin
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        status_rd_d  = (state_d == STROBE) && !sel_err_d;
        error_rd_d   = (state_d == STROBE) && sel_err_d;
        byte_valid_d = (state_d == SEND);
        byte_out_d   = (state_d == SEND) ? shift_d[31:24] : 8'h00;
        busy_d       = (state_d != IDLE);
    end

    // State, datapath and output registers; reset abandons any read.
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_err_q     <= 1'b0;
            wait_cnt_q    <= 8'd0;
            shift_q       <= 32'd0;
            byte_cnt_q    <= 2'd0;
            status_rd_q   <= 1'b0;
            error_rd_q    <= 1'b0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            bad_addr_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_err_q     <= sel_err_d;
            wait_cnt_q    <= wait_cnt_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            status_rd_q   <= status_rd_d;
            error_rd_q    <= error_rd_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            busy_q        <= busy_d;
            bad_addr_q    <= bad_addr_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.status_reg_read = status_rd_q;
    assign bus.error_reg_read  = error_rd_q;
    assign bus.byte_out        = byte_out_q;
    assign bus.byte_valid      = byte_valid_q;
    assign bus.busy            = busy_q;
    assign bus.bad_addr        = bad_addr_q;
    assign bus.timeout_err     = timeout_err_q;

endmodule
